rca2_fault_locator: RTL

//   Diagnosis stage for the reconfigurable double-fault RCA. During a test session it checks each

---
 rtl/rca2_fault_locator_if.sv | 46 ++++
 rtl/rca2_fault_locator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rca2_fault_locator_if.sv
// rtl/rca2_fault_locator_if.sv - TPG/adder observation inputs and diagnosis results of the fault locator
//
// Purpose : groups every non-clock/reset signal of rca2_fault_locator.
// Ports   : test, pat_valid, count[CW], at/bt[WIDTH], cint,
//           adder_sums/adder_carrys[WIDTH]            (master -> slave)
//           fault_map[WIDTH], f0_idx/f1_idx[IW], f0_vld, f1_vld,
//           too_many, seq_err, busy, done             (slave -> master)
// The slave modport is the locator; the master modport is whoever drives
// the test session (TPG / top level / testbench).

interface rca2_fault_locator_if #(
    parameter int WIDTH = 4,
    parameter int NPAT  = 8
);
    localparam int CW = $clog2(NPAT);
    localparam int IW = $clog2(WIDTH);

    logic             test;
    logic             pat_valid;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] at;
    logic [WIDTH-1:0] bt;
    logic             cint;
    logic [WIDTH-1:0] adder_sums;
    logic [WIDTH-1:0] adder_carrys;

    logic [WIDTH-1:0] fault_map;
    logic [IW-1:0]    f0_idx;
    logic             f0_vld;
    logic [IW-1:0]    f1_idx;
    logic             f1_vld;
    logic             too_many;
    logic             seq_err;
    logic             busy;
    logic             done;

    modport master (
        output test, pat_valid, count, at, bt, cint, adder_sums, adder_carrys,
        input  fault_map, f0_idx, f0_vld, f1_idx, f1_vld, too_many, seq_err, busy, done
    );

    modport slave (
        input  test, pat_valid, count, at, bt, cint, adder_sums, adder_carrys,
        output fault_map, f0_idx, f0_vld, f1_idx, f1_vld, too_many, seq_err, busy, done
    );
endinterface

// File: rtl/rca2_fault_locator.sv
// rtl/rca2_fault_locator.sv - per-stage fault diagnosis for the reconfigurable double-fault RCA
//
// Purpose : during a test session, checks each full-adder stage of the RCA
//           under test against the TPG pattern, accumulates a sticky fault
//           map, and at session end reports the two lowest faulty stages.
// Ports   : clk     rising-edge clock
//           init_n  asynchronous active-low reset
//           bus     rca2_fault_locator_if.slave (TPG/adder in, results out)

module rca2_fault_locator #(
    parameter int WIDTH = 4,
    parameter int NPAT  = 8
) (
    input  logic                 clk,
    input  logic                 init_n,
    rca2_fault_locator_if.slave  bus
);
    localparam int              CW       = $clog2(NPAT);
    localparam int              IW       = $clog2(WIDTH);
    localparam int              PW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_PAT = CW'(NPAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TEST,
        S_EVAL,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic start, take, abort, eval_en;

    logic [WIDTH-1:0] fault_map_q;
    logic [IW-1:0]    f0_q, f1_q;
    logic             f0_vld_q, f1_vld_q;
    logic             too_many_q;
    logic             seq_err_q;
    logic             done_q;
    logic [CW-1:0]    pcnt;

    // Each stage is judged against its actual upstream carry, so a single
    // faulty carry does not also flag every stage downstream of it.
    logic [WIDTH-1:0] cin_vec;
    logic [WIDTH-1:0] mismatch;

    assign cin_vec  = {bus.adder_carrys[WIDTH-2:0], bus.cint};
    assign mismatch = (bus.adder_sums ^ bus.at ^ bus.bt ^ cin_vec)
                    | (bus.adder_carrys ^ ((bus.at & bus.bt) | (bus.at & cin_vec) | (bus.bt & cin_vec)));

    // Two lowest set bits and population count of the fault map.
    logic [IW-1:0] f0_n, f1_n;
    logic          f0_vld_n, f1_vld_n;
    logic [PW-1:0] pop;

    always_comb begin
        f0_n     = '0;
        f1_n     = '0;
        f0_vld_n = 1'b0;
        f1_vld_n = 1'b0;
        pop      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (fault_map_q[i]) begin
                if (!f0_vld_n) begin
                    f0_n     = IW'(i);
                    f0_vld_n = 1'b1;
                end else if (!f1_vld_n) begin
                    f1_n     = IW'(i);
                    f1_vld_n = 1'b1;
                end
                pop = pop + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        take    = 1'b0;
        abort   = 1'b0;
        eval_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.test) begin
                    start   = 1'b1;
                    state_n = S_TEST;
                end
            end
            S_TEST: begin
                // A valid pattern always wins over test=0; the abort waits
                // for the next non-valid cycle.
                if (bus.pat_valid) begin
                    take = 1'b1;
                    if (pcnt == LAST_PAT) begin
                        state_n = S_EVAL;
                    end
                end else if (!bus.test) begin
                    abort   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_EVAL: begin
                eval_en = 1'b1;
                state_n = S_DONE;
            end
            S_DONE: begin
                if (!bus.test) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            fault_map_q <= '0;
            f0_q        <= '0;
            f1_q        <= '0;
            f0_vld_q    <= 1'b0;
            f1_vld_q    <= 1'b0;
            too_many_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            done_q      <= 1'b0;
            pcnt        <= '0;
        end else begin
            // done lags the state by one clock: it rises two clocks after the
            // last pattern and falls one clock after IDLE is re-entered.
            done_q <= (state == S_DONE);

            if (start) begin
                fault_map_q <= '0;
                f0_q        <= '0;
                f1_q        <= '0;
                f0_vld_q    <= 1'b0;
                f1_vld_q    <= 1'b0;
                too_many_q  <= 1'b0;
                seq_err_q   <= 1'b0;
                pcnt        <= '0;
            end

            if (take) begin
                fault_map_q <= fault_map_q | mismatch;
                seq_err_q   <= seq_err_q | (bus.count != pcnt);
                pcnt        <= (pcnt == LAST_PAT) ? '0 : pcnt + CW'(1);
            end

            if (abort) begin
                fault_map_q <= '0;
            end

            if (eval_en) begin
                f0_q       <= f0_n;
                f1_q       <= f1_n;
                f0_vld_q   <= f0_vld_n;
                f1_vld_q   <= f1_vld_n;
                too_many_q <= (pop > PW'(2));
            end
        end
    end

    assign bus.fault_map = fault_map_q;
    assign bus.f0_idx    = f0_q;
    assign bus.f0_vld    = f0_vld_q;
    assign bus.f1_idx    = f1_q;
    assign bus.f1_vld    = f1_vld_q;
    assign bus.too_many  = too_many_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.busy      = (state == S_TEST) || (state == S_EVAL);
    assign bus.done      = done_q;

endmodule
